// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EX stage (mult, multu, div, divu).
// Holds HI/LO for mfhi/mflo and raises busy while an operation is in flight.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no op in flight; accepts start or mthi/mtlo writes
//   CALC  | one shift-add (mul) or restoring step (div) per cycle, 32 cycles
//   FIX   | cycle 1: sign/boundary correction; cycle 2: write HI/LO, pulse done
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;      // product / quotient negative
    logic               rneg_q, rneg_d;    // remainder negative (dividend sign)
    logic               dz_q, dz_d;        // divide by zero
    logic [WIDTH-1:0]   araw_q, araw_d;    // raw dividend for the div-by-zero result
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: product; div: remainder in upper half
    logic [2*WIDTH-1:0] x_q, x_d;          // mul: shifted multiplicand; div: divisor
    logic [WIDTH-1:0]   y_q, y_d;          // mul: multiplier; div: dividend -> quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     rem_t, diff;
    logic               ge;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [2*WIDTH-1:0] res_fix;

    // Operand magnitudes, restoring-division trial subtract and final correction.
    always_comb begin
        signed_op = ~op[0];
        sa        = signed_op & src_a[WIDTH-1];
        sb        = signed_op & src_b[WIDTH-1];
        abs_a     = sa ? (~src_a + 1'b1) : src_a;
        abs_b     = sb ? (~src_b + 1'b1) : src_b;

        rem_t     = {acc_q[2*WIDTH-1:WIDTH], y_q[WIDTH-1]};
        diff      = rem_t - {1'b0, x_q[WIDTH-1:0]};
        ge        = ~diff[WIDTH];

        quo_fix   = neg_q  ? (~y_q + 1'b1) : y_q;
        rem_fix   = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q)
            res_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        else if (dz_q)
            res_fix = {araw_q, {WIDTH{1'b1}}};
        else
            res_fix = {rem_fix, quo_fix};
    end

    // Next-state logic for the FSM, datapath and HI/LO.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        araw_d   = araw_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_CALC;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    is_div_d = op[1];
                    neg_d    = sa ^ sb;
                    rneg_d   = sa;
                    dz_d     = op[1] && (src_b == '0);
                    araw_d   = src_a;
                    acc_d    = '0;
                    x_d      = {{WIDTH{1'b0}}, abs_b};
                    y_d      = abs_a;
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (!is_div_q) begin
                        if (y_q[0]) acc_d = acc_q + x_q;
                        x_d = {x_q[2*WIDTH-2:0], 1'b0};
                        y_d = {1'b0, y_q[WIDTH-1:1]};
                    end else begin
                        acc_d[2*WIDTH-1:WIDTH] = ge ? diff[WIDTH-1:0] : rem_t[WIDTH-1:0];
                        y_d = {y_q[WIDTH-2:0], ge};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (count_q == CW'(WIDTH)) begin
                    acc_d   = res_fix;
                    count_d = count_q + 1'b1;
                end else begin
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            araw_q   <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            araw_q   <= araw_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: hand-computed results and cycle timing.
module tb_mul_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: pulse start for one edge (edge E); returns at E + 1ns.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0;
        flush = 0; wr_hi = 0; wr_lo = 0; wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_multu;
        start_op(2'b01, 32'hFFFFFFFF, 32'h2);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_early_done: cycle %0d got %b expected 0", k, done); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    // Also checks HI/LO stay at the previous result through CALC and ignore mthi while busy.
    task automatic test_mult;
        start_op(2'b00, 32'hFFFFFFF9, 32'h3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_E: got %b expected 1", busy); end
        for (int k = 1; k <= 33; k++) begin
            if (k == 2) begin wr_hi = 1'b1; wdata = 32'h55; end
            @(posedge clk); #1;
            wr_hi = 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: cycle %0d got %b expected 1", k, busy); end
            checks++; if (hi !== 32'h1) begin errors++; $display("FAIL mult_hi_stable: cycle %0d got %h expected 00000001", k, hi); end
            checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo_stable: cycle %0d got %h expected fffffffe", k, lo); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    endtask

    task automatic test_back_to_back;
        start_op(2'b10, 32'hFFFFFFF9, 32'h2);
        repeat (33) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", done); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        repeat (33) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL divovf_done: got %b expected 1", done); end
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_divzero;
        start_op(2'b11, 32'd100, 32'h0);
        for (int k = 1; k <= 33; k++) begin
            if (k == 10) begin start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd5; end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL divz_done: got %b expected 1", done); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divz_hi: got %h expected 00000064", hi); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_no_restart: got %b expected 0", busy); end
    endtask

    task automatic test_flush;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'd9;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++; if (hi !== 32'd9) begin errors++; $display("FAIL preload_hi: got %h expected 00000009", hi); end
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL preload_lo: got %h expected 00000009", lo); end
        start_op(2'b00, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_no_done: cycle %0d got %b expected 0", k, done); end
        end
        checks++; if (hi !== 32'd9) begin errors++; $display("FAIL flush_hi: got %h expected 00000009", hi); end
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL flush_lo: got %h expected 00000009", lo); end
    endtask

    task automatic test_async_reset;
        start_op(2'b00, 32'hFFFFFFF9, 32'h3);
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL areset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL areset_lo: got %h expected 00000000", lo); end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle: got %b expected 0", busy); end
    endtask

    task automatic test_mthi;
        wr_hi = 1'b1; wdata = 32'd5;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mthi_hi: got %h expected 00000005", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_start_wins;
        op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1; wr_lo = 1'b1; wdata = 32'd77;
        @(posedge clk); #1;
        start = 1'b0; wr_lo = 1'b0;
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL startwins_lo: got %h expected 00000000", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startwins_busy: got %b expected 1", busy); end
        repeat (33) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL startwins_hi_res: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL startwins_lo_res: got %h expected 00000006", lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_back_to_back();
        test_divzero();
        test_flush();
        test_async_reset();
        test_mthi();
        test_start_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
